// File: rtl/i2c_target_rx.sv
// I2C target receive/transmit front end: synchronises SCL/SDA, detects START/STOP,
// matches a 7-bit address, ACKs open-drain, and moves bytes to and from the fabric.
module i2c_target_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addr_hit,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK} state_t;

  state_t      state_q, state_d;
  logic        scl_meta_q, scl_meta_d, scl_s_q, scl_s_d, scl_prev_q, scl_prev_d;
  logic        sda_meta_q, sda_meta_d, sda_s_q, sda_s_d, sda_prev_q, sda_prev_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic        ack_phase_q, ack_phase_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_req_q, tx_req_d;
  logic        addr_hit_q, addr_hit_d;
  logic        busy_q, busy_d;

  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  in_byte;

  assign scl_rise  = scl_s_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s_q & scl_prev_q;
  assign start_det = scl_s_q & scl_prev_q & sda_prev_q & ~sda_s_q;
  assign stop_det  = scl_s_q & scl_prev_q & ~sda_prev_q & sda_s_q;
  assign in_byte   = {shift_q[6:0], sda_s_q};

  always_comb begin
    scl_meta_d  = SCL;
    scl_s_d     = scl_meta_q;
    scl_prev_d  = scl_s_q;
    sda_meta_d  = SDA;
    sda_s_d     = sda_meta_q;
    sda_prev_d  = sda_s_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    ack_phase_d = ack_phase_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    addr_hit_d  = 1'b0;
    busy_d      = busy_q;

    // Bus conditions take priority over any SCL edge seen in the same cycle.
    if (start_det) begin
      state_d     = ADDR;
      bit_cnt_d   = 3'd0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      ack_phase_d = 1'b0;
    end else if (stop_det) begin
      state_d     = IDLE;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      ack_phase_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: if (scl_rise) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            // Address 0 (general call) is never claimed.
            if (in_byte[7:1] == SLAVE_ADDR && in_byte[7:1] != 7'd0) begin
              rw_d        = in_byte[0];
              addr_hit_d  = 1'b1;
              busy_d      = 1'b1;
              ack_phase_d = 1'b0;
              state_d     = ADDR_ACK;
            end else begin
              state_d = IDLE;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_oe_d    = 1'b1;
            ack_phase_d = 1'b1;
          end else begin
            ack_phase_d = 1'b0;
            bit_cnt_d   = 3'd0;
            if (rw_q) begin
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              state_d  = RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WR_DATA;
            end
          end
        end else if (scl_rise && ack_phase_q && rw_q) begin
          tx_req_d = 1'b1;
        end
        WR_DATA: if (scl_rise) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d   = in_byte;
            rx_valid_d  = 1'b1;
            ack_phase_d = 1'b0;
            state_d     = WR_ACK;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_oe_d    = 1'b1;
            ack_phase_d = 1'b1;
          end else begin
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b0;
            bit_cnt_d   = 3'd0;
            state_d     = WR_DATA;
          end
        end
        RD_DATA: if (scl_fall) begin
          shift_d = {shift_q[6:0], 1'b0};
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d    = 1'b0;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            state_d     = RD_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            sda_oe_d  = ~shift_q[6];
          end
        end
        RD_ACK: if (scl_rise) begin
          if (!sda_s_q) begin
            tx_req_d    = 1'b1;
            ack_phase_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = IDLE;
          end
        end else if (scl_fall && ack_phase_q) begin
          shift_d     = tx_data;
          sda_oe_d    = ~tx_data[7];
          bit_cnt_d   = 3'd0;
          ack_phase_d = 1'b0;
          state_d     = RD_DATA;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_q  <= 1'b1;
      scl_s_q     <= 1'b1;
      scl_prev_q  <= 1'b1;
      sda_meta_q  <= 1'b1;
      sda_s_q     <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      rw_q        <= 1'b0;
      ack_phase_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      addr_hit_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      scl_meta_q  <= scl_meta_d;
      scl_s_q     <= scl_s_d;
      scl_prev_q  <= scl_prev_d;
      sda_meta_q  <= sda_meta_d;
      sda_s_q     <= sda_s_d;
      sda_prev_q  <= sda_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      ack_phase_q <= ack_phase_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      addr_hit_q  <= addr_hit_d;
      busy_q      <= busy_d;
    end
  end

  // Open-drain: only ever pull low or let go.
  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign addr_hit = addr_hit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: a behavioural I2C master drives the bus and a
// transaction-level model predicts ACKs, written bytes and returned read bytes.
`timescale 1ns/1ps
module tb_i2c_target_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m;
  logic       m_sda_low;
  logic [7:0] tx_data;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, addr_hit, busy;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #10 clk = ~clk;

  i2c_target_rx #(.SLAVE_ADDR(7'h50)) dut (
    .clk(clk), .rst_n(rst_n), .SCL(scl_m), .SDA(sda_bus),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_req(tx_req), .addr_hit(addr_hit), .busy(busy)
  );

  int total, bad, q_ns;
  int rx_cnt, txreq_cnt, hit_cnt, low_cnt, tx_idx;
  logic [7:0] rx_log [256];
  logic [7:0] tx_mem [64];

  // Event monitors, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt % 256] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_req) begin
      tx_data   <= tx_mem[tx_idx % 64];
      tx_idx    <= tx_idx + 1;
      txreq_cnt <= txreq_cnt + 1;
    end
    if (addr_hit) hit_cnt <= hit_cnt + 1;
    if (!m_sda_low && sda_bus === 1'b0) low_cnt <= low_cnt + 1;
  end

  task automatic bit_slot(input logic drive_low, output logic seen);
    m_sda_low = drive_low;
    #(q_ns); scl_m = 1'b1;
    #(q_ns); seen = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
    #(q_ns); scl_m = 1'b0;
    #(q_ns);
  endtask

  task automatic i2c_start;
    m_sda_low = 1'b0;
    #(q_ns); scl_m = 1'b1;
    #(q_ns); m_sda_low = 1'b1;
    #(q_ns); scl_m = 1'b0;
    #(q_ns);
  endtask

  task automatic i2c_stop;
    m_sda_low = 1'b1;
    #(q_ns); scl_m = 1'b1;
    #(q_ns); m_sda_low = 1'b0;
    #(q_ns); #(q_ns);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_slot(~b[i], s);
    bit_slot(1'b0, ack);
  endtask

  task automatic recv_byte(input logic ack_it, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_slot(1'b0, s);
      d[i] = s;
    end
    bit_slot(ack_it, s);
  endtask

  function automatic logic exp_ack(input logic [7:0] addr_byte);
    return (addr_byte[7:1] == 7'h50) ? 1'b0 : 1'b1;
  endfunction

  task automatic test_reset;
    #100;
    total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b want=1", sda_bus); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    #200;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%02h want=00", rx_data); end
    total++; if ({rx_valid, tx_req, addr_hit} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {rx_valid, tx_req, addr_hit}); end
    $display("txn reset: released");
  endtask

  task automatic test_write;
    logic a0, a1;
    int r0, h0;
    r0 = rx_cnt; h0 = hit_cnt;
    q_ns = 2500;
    i2c_start();
    send_byte(8'hA0, a0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy_after_addr got=%b want=1", busy); end
    send_byte(8'hA5, a1);
    total++; if ({a0, a1} !== 2'b00) begin bad++; $display("FAIL write_acks got=%b want=00", {a0, a1}); end
    total++; if (rx_cnt - r0 != 1) begin bad++; $display("FAIL write_rx_valid_count got=%0d want=1", rx_cnt - r0); end
    total++; if (rx_log[r0 % 256] !== 8'hA5) begin bad++; $display("FAIL write_rx_data got=%02h want=a5", rx_log[r0 % 256]); end
    total++; if (hit_cnt - h0 != 1) begin bad++; $display("FAIL write_addr_hit got=%0d want=1", hit_cnt - h0); end
    i2c_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_after_stop got=%b want=0", busy); end
    q_ns = 500;
    $display("txn write: addr=a0 data=a5 acks=%b%b", a0, a1);
  endtask

  task automatic test_mismatch;
    logic a0, a1;
    int r0, h0, t0, l0;
    r0 = rx_cnt; h0 = hit_cnt; t0 = txreq_cnt; l0 = low_cnt;
    i2c_start();
    send_byte(8'hA2, a0);
    send_byte(8'h11, a1);
    i2c_stop();
    total++; if ({a0, a1} !== {exp_ack(8'hA2), 1'b1}) begin bad++; $display("FAIL mismatch_acks got=%b want=11", {a0, a1}); end
    total++; if (low_cnt != l0) begin bad++; $display("FAIL mismatch_sda_driven got=%0d want=0", low_cnt - l0); end
    total++; if (hit_cnt != h0 || rx_cnt != r0 || txreq_cnt != t0) begin bad++; $display("FAIL mismatch_pulses got=%0d/%0d/%0d want=0/0/0", hit_cnt - h0, rx_cnt - r0, txreq_cnt - t0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mismatch_busy got=%b want=0", busy); end
    $display("txn mismatch: addr=a2 acks=%b%b", a0, a1);
  endtask

  task automatic test_read;
    logic a0;
    logic [7:0] d0, d1;
    int t0;
    t0 = txreq_cnt;
    tx_mem[tx_idx % 64] = 8'h3C;
    tx_mem[(tx_idx + 1) % 64] = 8'hC3;
    i2c_start();
    send_byte(8'hA1, a0);
    recv_byte(1'b1, d0);
    recv_byte(1'b0, d1);
    total++; if (a0 !== 1'b0) begin bad++; $display("FAIL read_addr_ack got=%b want=0", a0); end
    total++; if (d0 !== 8'h3C) begin bad++; $display("FAIL read_byte0 got=%02h want=3c", d0); end
    total++; if (d1 !== 8'hC3) begin bad++; $display("FAIL read_byte1 got=%02h want=c3", d1); end
    total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL read_release_after_nack got=%b want=1", sda_bus); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL read_busy_after_nack got=%b want=1", busy); end
    i2c_stop();
    total++; if (txreq_cnt - t0 != 2) begin bad++; $display("FAIL read_tx_req_count got=%0d want=2", txreq_cnt - t0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_busy_after_stop got=%b want=0", busy); end
    $display("txn read: addr=a1 data=%02h %02h", d0, d1);
  endtask

  task automatic test_rep_start;
    logic a0, a1, a2;
    logic [7:0] wd, rd, d;
    int r0, h0;
    wd = 8'($urandom_range(1, 255));
    rd = 8'($urandom_range(0, 255));
    r0 = rx_cnt; h0 = hit_cnt;
    tx_mem[tx_idx % 64] = rd;
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(wd, a1);
    i2c_start();
    send_byte(8'hA1, a2);
    recv_byte(1'b0, d);
    i2c_stop();
    total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL rep_start_acks got=%b want=000", {a0, a1, a2}); end
    total++; if (rx_cnt - r0 != 1 || rx_log[r0 % 256] !== wd) begin bad++; $display("FAIL rep_start_rx got=%02h (n=%0d) want=%02h", rx_log[r0 % 256], rx_cnt - r0, wd); end
    total++; if (d !== rd) begin bad++; $display("FAIL rep_start_read got=%02h want=%02h", d, rd); end
    total++; if (hit_cnt - h0 != 2) begin bad++; $display("FAIL rep_start_hits got=%0d want=2", hit_cnt - h0); end
    $display("txn rep_start: wr=%02h rd=%02h", wd, d);
  endtask

  task automatic test_stop_mid;
    logic a0, a1, a2, s;
    logic [7:0] wd;
    int r0;
    r0 = rx_cnt;
    wd = 8'($urandom_range(1, 255));
    i2c_start();
    send_byte(8'hA0, a0);
    for (int i = 0; i < 4; i++) bit_slot(($urandom_range(0, 1) == 0), s);
    i2c_stop();
    total++; if (rx_cnt != r0) begin bad++; $display("FAIL stop_mid_rx_valid got=%0d want=0", rx_cnt - r0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_mid_busy got=%b want=0", busy); end
    i2c_start();
    send_byte(8'hA0, a1);
    send_byte(wd, a2);
    i2c_stop();
    total++; if ({a0, a1, a2} !== 3'b000 || rx_cnt - r0 != 1 || rx_log[r0 % 256] !== wd) begin bad++; $display("FAIL stop_mid_followup got=%b/%02h want=000/%02h", {a0, a1, a2}, rx_log[r0 % 256], wd); end
    $display("txn stop_mid: followup data=%02h", wd);
  endtask

  task automatic test_reset_mid;
    logic a0, a1, a2, a3;
    int l0;
    tx_mem[tx_idx % 64] = 8'h00;
    i2c_start();
    send_byte(8'hA1, a0);
    total++; if (sda_bus !== 1'b0) begin bad++; $display("FAIL reset_mid_driving got=%b want=0", sda_bus); end
    rst_n = 1'b0;
    #1;
    total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL reset_mid_release got=%b want=1", sda_bus); end
    total++; if ({busy, rx_data} !== 9'd0) begin bad++; $display("FAIL reset_mid_outputs got=%b/%02h want=0/00", busy, rx_data); end
    #50; rst_n = 1'b1; #(q_ns);
    l0 = low_cnt;
    send_byte(8'hA0, a1);
    i2c_stop();
    total++; if (a1 !== 1'b1 || low_cnt != l0) begin bad++; $display("FAIL reset_mid_no_ack got=%b/%0d want=1/0", a1, low_cnt - l0); end
    i2c_start();
    send_byte(8'hA0, a2);
    send_byte(8'h5A, a3);
    i2c_stop();
    total++; if ({a0, a2, a3} !== 3'b000) begin bad++; $display("FAIL reset_mid_reengage got=%b want=000", {a0, a2, a3}); end
    $display("txn reset_mid: reengaged");
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 5; t++) begin
      logic [6:0] a7;
      logic [7:0] ab, db, d;
      logic rw, hit, ack;
      int n, r0, t0, h0, k;
      a7 = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom_range(0, 127));
      if (a7 == 7'h50 && $urandom_range(0, 3) == 0) a7 = 7'h51;
      rw  = ($urandom_range(0, 1) == 1);
      n   = $urandom_range(1, 3);
      ab  = {a7, rw};
      hit = (exp_ack(ab) == 1'b0);
      r0 = rx_cnt; t0 = txreq_cnt; h0 = hit_cnt; k = 0;
      for (int j = 0; j < n; j++) tx_mem[(tx_idx + j) % 64] = 8'($urandom_range(0, 255));
      i2c_start();
      send_byte(ab, ack);
      total++; if (ack !== exp_ack(ab)) begin bad++; $display("FAIL b2b_addr_ack t=%0d got=%b want=%b", t, ack, exp_ack(ab)); end
      for (int j = 0; j < n; j++) begin
        if (!rw) begin
          db = 8'($urandom_range(0, 255));
          send_byte(db, ack);
          total++; if (ack !== !hit) begin bad++; $display("FAIL b2b_data_ack t=%0d got=%b want=%b", t, ack, !hit); end
          if (hit) begin
            total++; if (rx_log[(r0 + j) % 256] !== db) begin bad++; $display("FAIL b2b_rx t=%0d got=%02h want=%02h", t, rx_log[(r0 + j) % 256], db); end
            k++;
          end
        end else if (hit) begin
          db = tx_mem[(tx_idx - txreq_cnt + t0 + j) % 64];
          recv_byte(j != n - 1, d);
          total++; if (d !== db) begin bad++; $display("FAIL b2b_read t=%0d got=%02h want=%02h", t, d, db); end
        end
      end
      i2c_stop();
      total++; if (rx_cnt - r0 != k || txreq_cnt - t0 != ((rw && hit) ? n : 0) || hit_cnt - h0 != (hit ? 1 : 0)) begin
        bad++; $display("FAIL b2b_counts t=%0d got=%0d/%0d/%0d", t, rx_cnt - r0, txreq_cnt - t0, hit_cnt - h0);
      end
      $display("txn b2b %0d: addr=%02h rw=%b n=%0d hit=%b", t, a7, rw, n, hit);
    end
  endtask

  initial begin
    rst_n = 1'b0; scl_m = 1'b1; m_sda_low = 1'b0; q_ns = 500;
    #3;
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_rep_start();
    test_stop_mid();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
